fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding imem read, a single-entry hand-off
// register to decode, branch redirect, and a sticky misaligned-target fault.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    output logic        misalign,
    output logic [31:0] retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        redir;

    assign tgt   = br_pc + br_imm;
    // Redirects only matter while a fetch is in flight or held; they beat ack/ready.
    assign redir = br_taken && ((state == S_REQ) || (state == S_VALID));

    assign imem_req    = (state == S_REQ);
    assign instr_valid = (state == S_VALID);
    assign imem_addr   = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            instr_pc <= 32'h0;
            misalign <= 1'b0;
            retired  <= 32'h0;
        end else if (redir) begin
            pc <= tgt;
            if (tgt[1:0] != 2'b00) begin
                misalign <= 1'b1;
                state    <= S_FAULT;
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_REQ;
                S_REQ: if (imem_ack) begin
                    instr    <= imem_rdata;
                    instr_pc <= pc;
                    state    <= S_VALID;
                end
                S_VALID: if (instr_ready) begin
                    pc      <= pc + 32'd4;
                    retired <= retired + 32'd1;
                    state   <= S_REQ;
                end
                default: state <= S_FAULT;
            endcase
        end
    end

endmodule
